// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mem_arb_pkg
//  Brief  : Shared widths, port indices and request/response records for the
//           main-memory request arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 25;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;

  // Requester indices
  localparam logic IFETCH = 1'b0;
  localparam logic DATA   = 1'b1;

  typedef struct packed {
    logic                  wen;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_MASK_W-1:0] mask;
  } req_t;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
    logic                  err;
  } resp_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module : rr_arb2
//  Brief  : Two-way round-robin grant. A lone request is granted at once;
//           on a conflict the preferred port wins and priority moves to the
//           loser.
//  Rev    : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;      // 0: port 0 preferred, 1: port 1 preferred
  logic conflict;

  assign conflict = &req;

  // Grant decode: pass single requests through, resolve conflicts by prio
  always_comb begin
    gnt = req;
    if (conflict) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

  // Priority bit flips to the loser after every resolved conflict
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (conflict) begin
      prio <= ~prio;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_req_arb.sv
`default_nettype none
// ============================================================================
//  Module : mem_req_arb
//  Brief  : Ifetch/data requester arbiter in front of the 1R1W main-memory
//           SRAM. Reads and writes are arbitrated separately, reads return
//           one cycle after acceptance, out-of-range accesses are flagged.
//           Request/response records use the package widths, so ADDR_W and
//           DATA_W are expected to stay at the package values.
//  Rev    : 1.0  initial release
// ============================================================================
module mem_req_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int MEM_WORDS = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                p0_req_valid,
  output logic                p0_req_ready,
  input  logic                p0_req_wen,
  input  logic [ADDR_W-1:0]   p0_req_addr,
  input  logic [DATA_W-1:0]   p0_req_wdata,
  input  logic [DATA_W/8-1:0] p0_req_mask,
  output logic                p0_resp_valid,
  output logic [DATA_W-1:0]   p0_resp_data,
  output logic                p0_resp_err,
  input  logic                p1_req_valid,
  output logic                p1_req_ready,
  input  logic                p1_req_wen,
  input  logic [ADDR_W-1:0]   p1_req_addr,
  input  logic [DATA_W-1:0]   p1_req_wdata,
  input  logic [DATA_W/8-1:0] p1_req_mask,
  output logic                p1_resp_valid,
  output logic [DATA_W-1:0]   p1_resp_data,
  output logic                p1_resp_err,
  output logic                wr_err,
  output logic                mem_R0_en,
  output logic [ADDR_W-1:0]   mem_R0_addr,
  input  logic [DATA_W-1:0]   mem_R0_data,
  output logic                mem_W0_en,
  output logic [ADDR_W-1:0]   mem_W0_addr,
  output logic [DATA_W-1:0]   mem_W0_data,
  output logic [DATA_W/8-1:0] mem_W0_mask
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);

  // Unsigned full-width range check, no truncation
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    in_range = ({1'b0, a} < LIMIT);
  endfunction

  req_t [1:0] req;
  logic [1:0] valid;
  logic [1:0] rd_req, wr_req, rd_gnt, wr_gnt;
  logic       rd_sel, wr_sel, rd_any, wr_any, rd_ok, wr_ok;
  logic       pend, port, err;
  resp_t      resp, resp0, resp1;

  assign req[0] = '{wen: p0_req_wen, addr: p0_req_addr, wdata: p0_req_wdata, mask: p0_req_mask};
  assign req[1] = '{wen: p1_req_wen, addr: p1_req_addr, wdata: p1_req_wdata, mask: p1_req_mask};
  assign valid  = {p1_req_valid, p0_req_valid};

  // Requests are masked while reset is high so nothing is accepted then
  assign rd_req = valid & ~{req[1].wen, req[0].wen} & {2{~reset}};
  assign wr_req = valid &  {req[1].wen, req[0].wen} & {2{~reset}};

  rr_arb2 u_rd_arb (.clock(clock), .reset(reset), .req(rd_req), .gnt(rd_gnt));
  rr_arb2 u_wr_arb (.clock(clock), .reset(reset), .req(wr_req), .gnt(wr_gnt));

  assign p0_req_ready = rd_gnt[IFETCH] | wr_gnt[IFETCH];
  assign p1_req_ready = rd_gnt[DATA]   | wr_gnt[DATA];

  assign rd_any = |rd_gnt;
  assign wr_any = |wr_gnt;
  assign rd_sel = rd_gnt[DATA] ? DATA : IFETCH;
  assign wr_sel = wr_gnt[DATA] ? DATA : IFETCH;
  assign rd_ok  = rd_any & in_range(req[rd_sel].addr);
  assign wr_ok  = wr_any & in_range(req[wr_sel].addr);

  // SRAM port drive: granted in-range fields pass through, otherwise zeros
  always_comb begin
    mem_W0_en   = 1'b0;
    mem_W0_addr = '0;
    mem_W0_data = '0;
    mem_W0_mask = '0;
    mem_R0_en   = 1'b0;
    mem_R0_addr = '0;
    if (wr_ok) begin
      mem_W0_en   = 1'b1;
      mem_W0_addr = req[wr_sel].addr;
      mem_W0_data = req[wr_sel].wdata;
      mem_W0_mask = req[wr_sel].mask;
    end
    if (rd_ok) begin
      mem_R0_en   = 1'b1;
      mem_R0_addr = req[rd_sel].addr;
    end
  end

  // Read pipeline stage and dropped-write flag, both captured at grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend   <= 1'b0;
      port   <= IFETCH;
      err    <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      pend   <= rd_any;
      port   <= rd_sel;
      err    <= rd_any & ~rd_ok;
      wr_err <= wr_any & ~wr_ok;
    end
  end

  // Route the one-cycle-late read response to the port that issued it
  always_comb begin
    resp       = '0;
    resp.valid = pend;
    resp.err   = pend & err;
    resp.data  = (pend & ~err) ? mem_R0_data : '0;
    resp0      = (port == IFETCH) ? resp : '0;
    resp1      = (port == DATA)   ? resp : '0;
  end

  assign p0_resp_valid = resp0.valid;
  assign p0_resp_data  = resp0.data;
  assign p0_resp_err   = resp0.err;
  assign p1_resp_valid = resp1.valid;
  assign p1_resp_data  = resp1.data;
  assign p1_resp_err   = resp1.err;

endmodule
`default_nettype wire

// File: doc/mem_req_arb.md
Name: mem_req_arb

Overview:
- Two-requester arbiter/sequencer in front of the 1R1W main-memory SRAM macro (mem_ext; 25-bit word address, 64-bit data, byte mask, 1-cycle registered-address read).
- Port 0 is the instruction-fetch requester; port 1 is the data (load/store) requester.
- Grants requests onto the SRAM W0/R0 ports, returns read data to the issuing port, and rejects out-of-range addresses with an error response.

Parameters:
- ADDR_W, 25, word-address width (matches SRAM W0/R0_addr).
- DATA_W, 64, data width; mask width is DATA_W/8.
- MEM_WORDS, 128, implemented words; word addresses >= MEM_WORDS are out of range.

Ports:
- clock  in  1  single clock for the block and the SRAM (drives both W0_clk and R0_clk).
- reset  in  1  asynchronous, active-high.
- pN_req_valid  in  1  request valid, for N = 0, 1.
- pN_req_ready  out  1  request accepted this cycle (combinational from valids and arbitration state).
- pN_req_wen  in  1  1 = write, 0 = read.
- pN_req_addr  in  ADDR_W  word address.
- pN_req_wdata  in  DATA_W  write data.
- pN_req_mask  in  DATA_W/8  byte enables for writes.
- pN_resp_valid  out  1  read response valid (no backpressure).
- pN_resp_data  out  DATA_W  read data; 0 when resp_err = 1.
- pN_resp_err  out  1  qualifies resp_valid: out-of-range read.
- wr_err  out  1  one-cycle pulse when an accepted write is dropped as out-of-range.
- mem_R0_en  out  1  SRAM read enable.
- mem_R0_addr  out  ADDR_W  SRAM read address.
- mem_R0_data  in  DATA_W  SRAM read data, valid the cycle after mem_R0_en.
- mem_W0_en  out  1  SRAM write enable.
- mem_W0_addr  out  ADDR_W  SRAM write address.
- mem_W0_data  out  DATA_W  SRAM write data.
- mem_W0_mask  out  DATA_W/8  SRAM byte mask.

Behaviour:
- Handshake: a request transfers when valid & ready. Requesters hold all request fields stable while valid & !ready.
- Read and write classes are arbitrated independently, because the SRAM has separate R and W ports.
  - One port reading while the other writes: both are granted in the same cycle.
  - Both ports reading, or both writing: one grant per cycle, round-robin.
  - Single contender: granted immediately.
- Round-robin state: one bit `prio`, reset to 0 (port 0 preferred). After any cycle that resolves a same-class conflict, prio points to the loser.
- Non-conflict grants leave prio unchanged.
- Accepted write:
  - In range: mem_W0_en = 1 with addr, wdata and mask passed through combinationally in the same cycle.
  - Out of range: mem_W0_en = 0 and wr_err pulses in the next cycle.
- Accepted read:
  - In range: mem_R0_en = 1 with the address passed through.
  - Out of range: mem_R0_en = 0.
- Read pipeline register {pend, port, err} is captured at grant.
  - In the next cycle, p[port]_resp_valid = 1.
  - resp_data = mem_R0_data if err = 0, else 0; resp_err = err.
- Read latency: exactly 1 cycle from accept to response. Throughput: one read per port per cycle, with no stall for outstanding reads.
- Same-cycle read and write to the same in-range word: the SRAM is write-first, so the response carries post-write data merged per mask. The arbiter does not interfere.
- Idle outputs:
  - mem_*_en = 0; address, data and mask outputs are don't-care but driven to 0.
  - resp_valid = 0, resp_err = 0, resp_data = 0.
- Reset:
  - Clears prio, pend and wr_err; all outputs are 0 during reset.
  - A read accepted in the cycle reset asserts produces no response.
  - Ready outputs are 0 while reset is high.
- Range compare is unsigned, full ADDR_W width. No address truncation in the arbiter.

Decomposition:
- Shared package `mem_arb_pkg`:
  - ADDR_W and DATA_W defaults.
  - Request struct {wen, addr, wdata, mask}.
  - Response struct {valid, data, err}.
  - Port-index constants IFETCH = 0, DATA = 1.
- One sub-module, `rr_arb2`: 2-way round-robin grant with a registered priority bit. Instantiated twice, once for the read class and once for the write class.

Test Plan:
- Port 0 reads addr 5 with memory preloaded to 64'hDEAD_BEEF_0000_0005 → p0_resp_valid one cycle later with that data, resp_err = 0.
- Both ports request reads (addr 1, 2) continuously for 4 cycles → grants alternate 0, 1, 0, 1 starting at port 0 after reset; each response arrives 1 cycle after its grant with the correct data.
- Port 1 writes addr 3 with data 64'h1122334455667788 and mask 8'h0F, while port 0 reads addr 3 in the same cycle → both granted; read returns old[63:32] merged with 32'h55667788.
- Port 1 reads addr 200 (MEM_WORDS = 128) → mem_R0_en = 0, p1_resp_valid = 1, resp_err = 1, resp_data = 0. Port 0 writes addr 128 → mem_W0_en = 0, wr_err pulses once.
- Assert reset in the cycle a read is accepted → no resp_valid afterwards; prio = 0; first post-reset conflict is granted to port 0.
